// File: rtl/divider_ieee.sv
// rtl/divider_ieee.sv - iterative IEEE-754 single-precision divider, restoring radix-2, one quotient bit per cycle
module divider_ieee #(
  parameter int MANT_W   = 23,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quotient,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [MANT_W:0]     mb_q, mb_d;
  logic signed [9:0]   exp_raw_q, exp_raw_d;
  logic [MANT_W+2:0]   rem_q, rem_d;
  logic [MANT_W+1:0]   qbits_q, qbits_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                spec_q, spec_d;
  logic [31:0]         spec_res_q, spec_res_d;
  logic                spec_dbz_q, spec_dbz_d;
  logic [31:0]         quotient_q, quotient_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                dbz_q, dbz_d;

  logic                a_zero, b_zero, sign_in, rem_ge;
  logic [MANT_W+2:0]   rem_sub;
  logic signed [9:0]   exp_n;
  logic [MANT_W-1:0]   mant_n;

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mb_d       = mb_q;
    exp_raw_d  = exp_raw_q;
    rem_d      = rem_q;
    qbits_d    = qbits_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_dbz_d = spec_dbz_q;
    quotient_d = quotient_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    dbz_d      = dbz_q;

    a_zero  = (a[30:0] == 31'd0);
    b_zero  = (b[30:0] == 31'd0);
    sign_in = a[31] ^ b[31];
    rem_ge  = (rem_q >= {2'b00, mb_q});
    rem_sub = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    // A leading zero in the top quotient bit means ma < mb: shift one more and drop the exponent.
    exp_n   = qbits_q[MANT_W+1] ? exp_raw_q : (exp_raw_q - 10'sd1);
    mant_n  = qbits_q[MANT_W+1] ? qbits_q[MANT_W:1] : qbits_q[MANT_W-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d     = sign_in;
          mb_d       = {1'b1, b[MANT_W-1:0]};
          exp_raw_d  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
                       + $signed(10'(EXP_BIAS));
          rem_d      = {2'b00, 1'b1, a[MANT_W-1:0]};
          qbits_d    = '0;
          cnt_d      = 5'd24;
          busy_d     = 1'b1;
          spec_d     = a_zero | b_zero;
          spec_dbz_d = b_zero;
          if (b_zero)
            spec_res_d = a_zero ? 32'h7FC0_0000 : {sign_in, 8'hFF, 23'h0};
          else
            spec_res_d = {sign_in, 31'h0};
          state_d    = (a_zero | b_zero) ? FINISH : DIVIDE;
        end
      end
      DIVIDE: begin
        qbits_d = {qbits_q[MANT_W:0], rem_ge};
        rem_d   = rem_sub << 1;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        dbz_d   = 1'b0;
        if (spec_q) begin
          quotient_d = spec_res_q;
          dbz_d      = spec_dbz_q;
        end else if (exp_n > 10'sd254) begin
          quotient_d = {sign_q, 8'hFF, 23'h0};
          ovf_d      = 1'b1;
        end else if (exp_n < 10'sd1) begin
          quotient_d = {sign_q, 31'h0};
          unf_d      = 1'b1;
        end else begin
          quotient_d = {sign_q, exp_n[7:0], mant_n};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mb_q       <= '0;
      exp_raw_q  <= '0;
      rem_q      <= '0;
      qbits_q    <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_dbz_q <= 1'b0;
      quotient_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mb_q       <= mb_d;
      exp_raw_q  <= exp_raw_d;
      rem_q      <= rem_d;
      qbits_q    <= qbits_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_dbz_q <= spec_dbz_d;
      quotient_q <= quotient_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      dbz_q      <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_ieee.sv
// tb/tb_divider_ieee.sv - vector table plus scoreboard bench for divider_ieee
module tb_divider_ieee;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] quotient;
  logic        busy, done, overflow, underflow, div_by_zero;

  divider_ieee dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .quotient(quotient), .busy(busy), .done(done),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
    logic        unf;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   e0;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb_q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops the oldest expectation and checks result, flags and latency.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=1 required=0");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("quotient", quotient, e.v.q);
        chk("flags", {29'd0, overflow, underflow, div_by_zero},
            {29'd0, e.v.ovf, e.v.unf, e.v.dbz});
        chk("latency", edge_cnt - e.e0, e.v.lat);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called on a negedge; returns on the negedge following E0.
  task automatic issue(input vec_t v);
    sb_t e;
    a = v.a;
    b = v.b;
    start = 1'b1;
    e.v = v;
    e.e0 = edge_cnt + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    int low = 0;
    while (!done && n < 60) begin
      if (!busy) low++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    chk("busy_held", low, 0);
  endtask

  initial begin
    vec_t alt;
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 26};
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 1'b0, 26};
    vecs[2] = '{32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, 1'b0, 1'b0, 26};
    vecs[3] = '{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 26};
    vecs[7] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 26};
    vecs[8] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 1};
    alt     = '{32'h41200000, 32'h40A00000, 32'h40000000, 1'b0, 1'b0, 1'b0, 26};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_quotient", quotient, 32'h0);
    chk("reset_ctrl", {27'd0, busy, done, overflow, underflow, div_by_zero}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i]);
      wait_done();
      @(negedge clk);
    end

    // Result and flags hold while idle.
    repeat (5) @(negedge clk);
    chk("hold_quotient", quotient, vecs[8].q);

    // Second start at E10 must be ignored.
    issue(vecs[1]);
    repeat (9) @(negedge clk);
    a = alt.a;
    b = alt.b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Back-to-back: start asserted in the done cycle.
    issue(vecs[0]);
    wait_done();
    issue(alt);
    wait_done();
    repeat (30) @(negedge clk);

    // Asynchronous reset at E12 aborts the operation.
    issue(vecs[2]);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_quotient", quotient, 32'h0);
    chk("async_rst_ctrl", {27'd0, busy, done, overflow, underflow, div_by_zero}, 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(vecs[1]);
    wait_done();
    @(negedge clk);
    chk("queue_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
